cp0_exc: RTL

CP0_EXC -- requirements
Module: cp0_exc

---
 rtl/cp0_exc.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cp0_exc.sv
// cp0_exc: MIPS-style coprocessor 0 register file and exception arbiter.
// Holds Status/Cause/EPC/PRId. Count/Compare and the timer interrupt exist
// only when CP0_TIMER_EN is defined; otherwise they read as 0 and
// timer_int_o is tied low.
// mtc0 writes are forwarded to mfc0 reads and to the exception logic, so an
// exception decided in the same cycle as a write sees the new value.
module cp0_exc (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] data_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] mem_excepttype_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_epc_o,
    output logic        timer_int_o
);

    localparam logic [4:0]  A_COUNT   = 5'd9;
    localparam logic [4:0]  A_COMPARE = 5'd11;
    localparam logic [4:0]  A_STATUS  = 5'd12;
    localparam logic [4:0]  A_CAUSE   = 5'd13;
    localparam logic [4:0]  A_EPC     = 5'd14;
    localparam logic [4:0]  A_PRID    = 5'd15;
    localparam logic [31:0] PRID_VAL  = 32'h004C0102;
    localparam logic [31:0] STATUS_RST = 32'h10000000;
    localparam logic [31:0] EXC_INT   = 32'h1;
    localparam logic [31:0] EXC_INV   = 32'hA;
    localparam logic [31:0] EXC_ERET  = 32'hE;

    logic [31:0] r_status, r_cause, r_epc;
    logic [31:0] w_count, w_compare;
    logic [31:0] w_status_fwd, w_cause_fwd, w_epc_fwd;
    logic        w_int_pend;
    logic [31:0] w_exc;
    logic        w_wr_status, w_wr_cause, w_wr_epc;
    logic        w_unused_ok;

    assign w_wr_status = we_i && (waddr_i == A_STATUS);
    assign w_wr_cause  = we_i && (waddr_i == A_CAUSE);
    assign w_wr_epc    = we_i && (waddr_i == A_EPC);

`ifdef CP0_TIMER_EN
    logic [31:0] r_count, r_compare;
    logic        r_timer_int;

    // Free-running counter, compare match raises a sticky timer interrupt
    // that only a Compare write clears (the write wins over a same-cycle match).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_compare   <= '0;
            r_timer_int <= 1'b0;
        end else begin
            r_count <= r_count + 32'd1;
            if ((r_compare != '0) && (r_count == r_compare))
                r_timer_int <= 1'b1;
            if (we_i && (waddr_i == A_COUNT))
                r_count <= data_i;
            if (we_i && (waddr_i == A_COMPARE)) begin
                r_compare   <= data_i;
                r_timer_int <= 1'b0;
            end
        end
    end

    assign w_count     = r_count;
    assign w_compare   = r_compare;
    assign timer_int_o = r_timer_int;
`else
    assign w_count     = '0;
    assign w_compare   = '0;
    assign timer_int_o = 1'b0;
`endif

    // Forwarded views: Cause only takes IP[9:8] from software.
    assign w_status_fwd = w_wr_status ? data_i : r_status;
    assign w_cause_fwd  = w_wr_cause ? {r_cause[31:10], data_i[9:8], r_cause[7:0]} : r_cause;
    assign w_epc_fwd    = w_wr_epc ? data_i : r_epc;
    assign cp0_epc_o    = w_epc_fwd;

    assign w_int_pend = (|(w_cause_fwd[15:8] & w_status_fwd[15:8]))
                        && w_status_fwd[0] && !w_status_fwd[1];

    // Exception priority: bubble, interrupt, invalid instruction, eret.
    always_comb begin
        w_exc = '0;
        if (rst || (mem_pc_i == '0))
            w_exc = '0;
        else if (w_int_pend)
            w_exc = EXC_INT;
        else if (mem_excepttype_i[9])
            w_exc = EXC_INV;
        else if (mem_excepttype_i[12])
            w_exc = EXC_ERET;
    end
    assign excepttype_o = w_exc;

    // Status/Cause/EPC: mtc0 applied first, exception updates override.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= STATUS_RST;
            r_cause  <= '0;
            r_epc    <= '0;
        end else begin
            r_cause[15:10] <= int_i;
            if (w_wr_status) r_status    <= data_i;
            if (w_wr_cause)  r_cause[9:8] <= data_i[9:8];
            if (w_wr_epc)    r_epc       <= data_i;
            if ((w_exc == EXC_INT) || (w_exc == EXC_INV)) begin
                r_epc       <= mem_in_delayslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
                r_cause[31] <= mem_in_delayslot_i;
                r_status[1] <= 1'b1;
                r_cause[6:2] <= (w_exc == EXC_INT) ? 5'd0 : 5'd10;
            end else if (w_exc == EXC_ERET) begin
                r_status[1] <= 1'b0;
            end
        end
    end

    // mfc0 read mux with write forwarding on implemented registers.
    always_comb begin
        data_o = '0;
        case (raddr_i)
            A_COUNT:   data_o = w_count;
            A_COMPARE: data_o = w_compare;
            A_STATUS:  data_o = w_status_fwd;
            A_CAUSE:   data_o = w_cause_fwd;
            A_EPC:     data_o = w_epc_fwd;
            A_PRID:    data_o = PRID_VAL;
            default:   data_o = '0;
        endcase
`ifdef CP0_TIMER_EN
        if (we_i && (waddr_i == raddr_i) &&
            ((raddr_i == A_COUNT) || (raddr_i == A_COMPARE)))
            data_o = data_i;
`endif
    end

    // Flag bits this block does not decode.
    assign w_unused_ok = &{1'b0, mem_excepttype_i[31:13], mem_excepttype_i[11:10],
                           mem_excepttype_i[8:0]};

endmodule
